keypad_scanner: RTL and testbench

Parametrised, clocked successor to the combinational keypad decoder. Drives one matrix row at a time, samples the column lines, debounces the result over whole scan frames, and rejects multi-key (ghost) frames. Emits one buffered key event per physical press, with a valid/ack handshake towards the consuming datapath. Sits between the keypad pins and the lab's input-handling logic.

---
 rtl/keypad_pkg.sv | 33 +++
 rtl/keypad_row_scanner.sv | 97 +++++++++
 rtl/keypad_scanner.sv | 154 +++++++++++++++
 tb/tb_keypad_scanner.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
//==============================================================================
// keypad_pkg
// Shared types and helpers for the keypad matrix scanner.
// Revision: 1.0
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

package keypad_pkg;

    localparam int STATE_W = 2;
    localparam int CLASS_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE       = 2'd0,
        ST_PRESS_DB   = 2'd1,
        ST_HELD       = 2'd2,
        ST_RELEASE_DB = 2'd3
    } state_e;

    typedef enum logic [CLASS_W-1:0] {
        FR_NONE  = 2'd0,
        FR_KEY   = 2'd1,
        FR_GHOST = 2'd2
    } frame_e;

    function automatic int code_width(input int rows, input int cols);
        return (rows * cols > 1) ? $clog2(rows * cols) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_row_scanner.sv
//==============================================================================
// keypad_row_scanner
// Strobes one row at a time and classifies each complete scan frame.
// Revision: 1.0
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module keypad_row_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS        = 4,
    parameter int COLS        = 3,
    parameter int SCAN_CYCLES = 4,
    parameter int CW          = 4
) (
    input  logic            clock,
    input  logic            reset,
    output logic [ROWS-1:0] row_drive,
    input  logic [COLS-1:0] col_sense,
    output logic            frame_done,
    output frame_e          frame_class,
    output logic [CW-1:0]   frame_code
);

    localparam int DW = $clog2(SCAN_CYCLES);
    localparam int RW = $clog2(ROWS);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYCLES - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);

    logic [DW-1:0] r_dwell;
    logic [RW-1:0] r_row;
    logic [1:0]    r_hits;
    logic [CW-1:0] r_code;

    logic          w_sample;
    logic [1:0]    w_row_hits;
    logic [CW-1:0] w_row_code;
    logic [2:0]    w_sum;
    logic [1:0]    w_hits;
    logic [CW-1:0] w_code;

    assign w_sample   = (r_dwell == DWELL_LAST);
    assign frame_done = w_sample && (r_row == ROW_LAST);

    // Hit count saturates at 2: anything beyond one key is a ghost frame.
    always_comb begin
        w_row_hits = 2'd0;
        w_row_code = '0;
        for (int c = 0; c < COLS; c++) begin
            if (col_sense[c]) begin
                w_row_code = CW'(int'(r_row) * COLS + c);
                w_row_hits = (w_row_hits == 2'd0) ? 2'd1 : 2'd2;
            end
        end
    end

    assign w_sum  = {1'b0, r_hits} + {1'b0, w_row_hits};
    assign w_hits = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
    assign w_code = (r_hits == 2'd0) ? w_row_code : r_code;

    // Class includes the final row's sample so the FSM can act on the same edge.
    always_comb begin
        frame_code = w_code;
        case (w_hits)
            2'd0:    frame_class = FR_NONE;
            2'd1:    frame_class = FR_KEY;
            default: frame_class = FR_GHOST;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_dwell   <= '0;
            r_row     <= '0;
            row_drive <= {{(ROWS-1){1'b0}}, 1'b1};
            r_hits    <= 2'd0;
            r_code    <= '0;
        end else if (w_sample) begin
            r_dwell   <= '0;
            r_row     <= (r_row == ROW_LAST) ? '0 : r_row + RW'(1);
            row_drive <= {row_drive[ROWS-2:0], row_drive[ROWS-1]};
            if (frame_done) begin
                r_hits <= 2'd0;
                r_code <= '0;
            end else begin
                r_hits <= w_hits;
                r_code <= w_code;
            end
        end else begin
            r_dwell <= r_dwell + DW'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/keypad_scanner.sv
//==============================================================================
// keypad_scanner
// Frame-debounced keypad scanner with ghost rejection and a one-entry event buffer.
// Revision: 1.0
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module keypad_scanner
    import keypad_pkg::*;
#(
    parameter  int ROWS        = 4,
    parameter  int COLS        = 3,
    parameter  int SCAN_CYCLES = 4,
    parameter  int DEBOUNCE    = 3,
    localparam int CW          = code_width(ROWS, COLS)
) (
    input  logic            clock,
    input  logic            reset,
    output logic [ROWS-1:0] row_drive,
    input  logic [COLS-1:0] col_sense,
    output logic            key_valid,
    output logic [CW-1:0]   key_code,
    input  logic            key_ack,
    output logic            key_down,
    output logic            overflow
);

    localparam int NW = $clog2(DEBOUNCE + 1);
    localparam logic [NW-1:0] CNT_LAST = NW'(DEBOUNCE - 1);

    logic          w_frame_done;
    frame_e        w_frame_class;
    logic [CW-1:0] w_frame_code;

    state_e        r_state;
    state_e        w_state_next;
    logic [CW-1:0] r_cand;
    logic [CW-1:0] w_cand_next;
    logic [NW-1:0] r_cnt;
    logic [NW-1:0] w_cnt_next;
    logic          w_accept;
    logic [CW-1:0] w_accept_code;

    keypad_row_scanner #(
        .ROWS        (ROWS),
        .COLS        (COLS),
        .SCAN_CYCLES (SCAN_CYCLES),
        .CW          (CW)
    ) u_row_scanner (
        .clock       (clock),
        .reset       (reset),
        .row_drive   (row_drive),
        .col_sense   (col_sense),
        .frame_done  (w_frame_done),
        .frame_class (w_frame_class),
        .frame_code  (w_frame_code)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cand  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cand  <= w_cand_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_cand_next   = r_cand;
        w_cnt_next    = r_cnt;
        w_accept      = 1'b0;
        w_accept_code = r_cand;
        if (w_frame_done) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_frame_class == FR_KEY) begin
                        if (DEBOUNCE == 1) begin
                            w_state_next  = ST_HELD;
                            w_accept      = 1'b1;
                            w_accept_code = w_frame_code;
                        end else begin
                            w_state_next = ST_PRESS_DB;
                            w_cand_next  = w_frame_code;
                            w_cnt_next   = NW'(1);
                        end
                    end
                end
                ST_PRESS_DB: begin
                    if (w_frame_class != FR_KEY) begin
                        w_state_next = ST_IDLE;
                    end else if (w_frame_code != r_cand) begin
                        w_cand_next = w_frame_code;
                        w_cnt_next  = NW'(1);
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_next = ST_HELD;
                        w_accept     = 1'b1;
                    end else begin
                        w_cnt_next = r_cnt + NW'(1);
                    end
                end
                ST_HELD: begin
                    if (w_frame_class == FR_NONE) begin
                        if (DEBOUNCE == 1) begin
                            w_state_next = ST_IDLE;
                        end else begin
                            w_state_next = ST_RELEASE_DB;
                            w_cnt_next   = NW'(1);
                        end
                    end
                end
                ST_RELEASE_DB: begin
                    if (w_frame_class != FR_NONE) begin
                        w_state_next = ST_HELD;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_cnt_next = r_cnt + NW'(1);
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        key_down = (r_state == ST_HELD) || (r_state == ST_RELEASE_DB);
    end

    // A same-cycle ack frees the slot, so the new event replaces the old one.
    always_ff @(posedge clock) begin
        if (reset) begin
            key_valid <= 1'b0;
            key_code  <= '0;
            overflow  <= 1'b0;
        end else if (w_accept) begin
            if (!key_valid || key_ack) begin
                key_valid <= 1'b1;
                key_code  <= w_accept_code;
            end else begin
                overflow <= 1'b1;
            end
        end else if (key_ack) begin
            key_valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_keypad_scanner.sv
//==============================================================================
// tb_keypad_scanner
// Keypad matrix model, directed scenarios and a scoreboarded random press stream.
// Revision: 1.0
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_keypad_scanner;

    localparam int ROWS        = 4;
    localparam int COLS        = 3;
    localparam int SCAN_CYCLES = 4;
    localparam int DEBOUNCE    = 3;
    localparam int NKEYS       = ROWS * COLS;
    localparam int FRAME       = ROWS * SCAN_CYCLES;
    localparam int CW          = $clog2(NKEYS);

    typedef struct {
        int code;
        int at_edge;
    } exp_t;

    logic             clock;
    logic             reset;
    logic [ROWS-1:0]  row_drive;
    logic [COLS-1:0]  col_sense;
    logic             key_valid;
    logic [CW-1:0]    key_code;
    logic             key_ack;
    logic             key_down;
    logic             overflow;

    logic [NKEYS-1:0] keys;
    logic             dir_ack;
    logic             mon_ack = 1'b0;
    logic             mon_en  = 1'b0;
    logic             pre_end_valid;
    int               edge_cnt = 0;
    int               n_checks = 0;
    int               n_err    = 0;

    exp_t             exp_q[$];
    exp_t             ev;
    bit               m_held;
    int               m_run_code;
    int               m_run_len;
    int               m_rel_len;

    keypad_scanner #(
        .ROWS        (ROWS),
        .COLS        (COLS),
        .SCAN_CYCLES (SCAN_CYCLES),
        .DEBOUNCE    (DEBOUNCE)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .row_drive (row_drive),
        .col_sense (col_sense),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_ack   (key_ack),
        .key_down  (key_down),
        .overflow  (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    // Physical matrix: a pressed key shorts its row line onto its column line.
    always_comb begin
        col_sense = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (row_drive[r] && keys[r*COLS + c]) col_sense[c] = 1'b1;
    end

    assign key_ack = mon_en ? mon_ack : dir_ack;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [NKEYS-1:0] key(input int code);
        logic [NKEYS-1:0] v;
        v = '0;
        v[code] = 1'b1;
        return v;
    endfunction

    // Reference: a press is a run of DEBOUNCE identical single-key frames while
    // released; a release is a run of DEBOUNCE empty frames while held.
    task automatic model_frame(input logic [NKEYS-1:0] pat, input int start_edge);
        int n;
        int c;
        exp_t e;
        n = $countones(pat);
        c = -1;
        for (int i = 0; i < NKEYS; i++) if (pat[i]) c = i;
        if (!m_held) begin
            if (n == 1) begin
                if (c == m_run_code) m_run_len++;
                else begin
                    m_run_code = c;
                    m_run_len  = 1;
                end
                if (m_run_len == DEBOUNCE) begin
                    m_held     = 1'b1;
                    m_rel_len  = 0;
                    m_run_code = -1;
                    m_run_len  = 0;
                    e.code     = c;
                    e.at_edge  = start_edge + FRAME;
                    exp_q.push_back(e);
                end
            end else begin
                m_run_code = -1;
                m_run_len  = 0;
            end
        end else begin
            if (n == 0) begin
                m_rel_len++;
                if (m_rel_len == DEBOUNCE) m_held = 1'b0;
            end else begin
                m_rel_len = 0;
            end
        end
    endtask

    task automatic run_frame(input logic [NKEYS-1:0] pat, input bit ack_first, input bit ack_last);
        int s;
        keys    = pat;
        dir_ack = ack_first;
        s       = edge_cnt;
        if (mon_en) model_frame(pat, s);
        for (int i = 0; i < FRAME; i++) begin
            @(posedge clock);
            #1;
            dir_ack = ack_last && (i == FRAME - 2);
            if (i == FRAME - 2) pre_end_valid = key_valid;
        end
        if (mon_en) chk("key_down_vs_model", key_down, m_held);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        keys    = '0;
        dir_ack = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Acks every event the cycle it is seen, so each valid sample is a fresh event.
    always @(negedge clock) begin
        if (mon_en && key_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL event_unexpected: got code %0d at edge %0d, required no event", key_code, edge_cnt);
            end else begin
                ev = exp_q.pop_front();
                chk("event_code", key_code, ev.code);
                chk("event_edge", edge_cnt, ev.at_edge);
            end
            mon_ack = 1'b1;
        end else begin
            mon_ack = 1'b0;
        end
    end

    initial begin
        logic [NKEYS-1:0] pat;
        logic [NKEYS-1:0] prev;
        int r;
        int a;
        int b;

        reset   = 1'b1;
        keys    = '0;
        dir_ack = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_row_drive", row_drive, 1);
        chk("reset_key_valid", key_valid, 0);
        chk("reset_key_code", key_code, 0);
        chk("reset_key_down", key_down, 0);
        chk("reset_overflow", overflow, 0);
        reset = 1'b0;
        for (int k = 0; k < FRAME; k++) begin
            chk("row_drive_step", row_drive, 1 << (k / SCAN_CYCLES));
            @(posedge clock);
            #1;
        end

        // Steady press of code 7, then release.
        repeat (2) run_frame(key(7), 1'b0, 1'b0);
        run_frame(key(7), 1'b0, 1'b0);
        chk("press_not_early", pre_end_valid, 0);
        chk("press_valid", key_valid, 1);
        chk("press_code", key_code, 7);
        chk("press_key_down", key_down, 1);
        run_frame(key(7), 1'b1, 1'b0);
        chk("no_auto_repeat", key_valid, 0);
        chk("held_key_down", key_down, 1);
        repeat (2) run_frame('0, 1'b0, 1'b0);
        chk("release_pending", key_down, 1);
        run_frame('0, 1'b0, 1'b0);
        chk("release_key_down", key_down, 0);
        chk("release_no_event", key_valid, 0);

        // Bounce: 7, none, 7, 7, 7.
        run_frame(key(7), 1'b0, 1'b0);
        run_frame('0, 1'b0, 1'b0);
        repeat (2) run_frame(key(7), 1'b0, 1'b0);
        chk("bounce_no_early_event", key_valid, 0);
        run_frame(key(7), 1'b0, 1'b0);
        chk("bounce_not_early", pre_end_valid, 0);
        chk("bounce_valid", key_valid, 1);
        chk("bounce_code", key_code, 7);
        run_frame('0, 1'b1, 1'b0);
        repeat (2) run_frame('0, 1'b0, 1'b0);
        chk("bounce_acked", key_valid, 0);
        chk("bounce_released", key_down, 0);

        // Ghost: keys 0 and 5 together.
        repeat (4) run_frame(key(0) | key(5), 1'b0, 1'b0);
        chk("ghost_no_event", key_valid, 0);
        chk("ghost_key_down", key_down, 0);
        run_frame('0, 1'b0, 1'b0);

        // Overflow: 4 left unacked, then 9.
        repeat (3) run_frame(key(4), 1'b0, 1'b0);
        chk("ovf_first_valid", key_valid, 1);
        chk("ovf_first_code", key_code, 4);
        chk("ovf_not_yet", overflow, 0);
        repeat (3) run_frame('0, 1'b0, 1'b0);
        repeat (3) run_frame(key(9), 1'b0, 1'b0);
        chk("ovf_code_kept", key_code, 4);
        chk("ovf_valid_kept", key_valid, 1);
        chk("ovf_set", overflow, 1);
        chk("ovf_key_down", key_down, 1);
        run_frame('0, 1'b1, 1'b0);
        chk("ovf_acked", key_valid, 0);
        chk("ovf_sticky", overflow, 1);
        repeat (2) run_frame('0, 1'b0, 1'b0);

        // Accept and ack on the same edge.
        do_reset();
        chk("reset_clears_ovf", overflow, 0);
        repeat (3) run_frame(key(3), 1'b0, 1'b0);
        repeat (3) run_frame('0, 1'b0, 1'b0);
        chk("pending3_valid", key_valid, 1);
        chk("pending3_code", key_code, 3);
        repeat (2) run_frame(key(5), 1'b0, 1'b0);
        run_frame(key(5), 1'b0, 1'b1);
        chk("race_code", key_code, 5);
        chk("race_valid", key_valid, 1);
        chk("race_no_ovf", overflow, 0);
        run_frame('0, 1'b1, 1'b0);
        repeat (2) run_frame('0, 1'b0, 1'b0);

        // Reset during press debounce.
        run_frame(key(7), 1'b0, 1'b0);
        keys = key(7);
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("midreset_row_drive", row_drive, 1);
        chk("midreset_key_valid", key_valid, 0);
        chk("midreset_key_down", key_down, 0);
        reset = 1'b0;
        repeat (2) run_frame(key(7), 1'b0, 1'b0);
        run_frame('0, 1'b0, 1'b0);
        chk("midreset_no_event", key_valid, 0);
        chk("midreset_no_down", key_down, 0);

        // Random press stream against the reference model.
        do_reset();
        m_held     = 1'b0;
        m_run_code = -1;
        m_run_len  = 0;
        m_rel_len  = 0;
        mon_en     = 1'b1;
        prev       = '0;
        for (int f = 0; f < 120; f++) begin
            r = $urandom_range(0, 99);
            if (r < 60) pat = prev;
            else if (r < 76) pat = '0;
            else if (r < 93) pat = key($urandom_range(0, NKEYS - 1));
            else begin
                a   = $urandom_range(0, NKEYS - 1);
                b   = (a + 1 + $urandom_range(0, NKEYS - 2)) % NKEYS;
                pat = key(a) | key(b);
            end
            run_frame(pat, 1'b0, 1'b0);
            prev = pat;
        end
        repeat (3) run_frame('0, 1'b0, 1'b0);
        repeat (4) @(posedge clock);
        #1;
        chk("events_outstanding", exp_q.size(), 0);
        mon_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
